// File: rtl/instr_loader.sv
// Instruction loader: assembles MSB-first bytes from the UART into 32-bit words and writes them to instruction memory.
// Latency: the write strobe follows the 4th byte by one cycle; the pipeline is released the cycle after the final write.
// Backpressure: none; one byte per cycle is sustained, and a byte that arrives on the terminating write cycle is dropped.
module instr_loader #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_BYTE   = 8,
  parameter int                 NB_IADDR  = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = {NB_DATA{1'b1}}
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_we_IF,
  output logic [NB_DATA-1:0]  o_instruction_data,
  output logic                o_pipe_rst_n,
  output logic                o_loading,
  output logic                o_done,
  output logic                o_overflow,
  output logic [NB_IADDR:0]   o_word_count
);

  localparam int MAX_WORDS      = 2 ** NB_IADDR;
  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int NB_ASM         = NB_DATA - NB_BYTE;

  // Index of the byte that completes a word, and the count value held during the final permitted write.
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);
  localparam logic [NB_IADDR:0] LAST_CNT  = (NB_IADDR + 1)'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [1:0]           byte_cnt_q;
  logic [NB_ASM-1:0]    asm_q;
  logic [NB_DATA-1:0]   data_q;
  logic                 we_q;
  logic                 pipe_rst_n_q;
  logic                 loading_q;
  logic                 done_q;
  logic                 overflow_q;
  logic [NB_IADDR:0]    word_cnt_q;

  logic                 is_halt;
  logic                 is_full;
  logic                 terminate;
  logic                 accept;

  // Termination decision for the word currently on the write port, and byte acceptance gating.
  always_comb begin
    is_halt   = 1'b0;
    is_full   = 1'b0;
    terminate = 1'b0;
    accept    = 1'b0;
    is_halt   = (data_q == HALT_WORD);
    is_full   = (word_cnt_q == LAST_CNT);
    terminate = we_q && (is_halt || is_full);
    // A byte landing on the terminating write cycle would belong to a load that is ending, so it is dropped.
    accept    = (state_q == ST_LOAD) && i_rx_valid && !terminate;
  end

  // Load FSM with all outputs registered: byte assembly, write pulse, word count and pipeline-reset control.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      pipe_rst_n_q <= 1'b0;
      loading_q    <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      we_q <= 1'b0;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state_q      <= ST_LOAD;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            pipe_rst_n_q <= 1'b0;
            loading_q    <= 1'b1;
            done_q       <= 1'b0;
          end
        end

        ST_LOAD: begin
          // Account for the word being written this cycle and decide whether the load ends here.
          if (we_q) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            if (terminate) begin
              state_q      <= ST_DONE;
              loading_q    <= 1'b0;
              done_q       <= 1'b1;
              pipe_rst_n_q <= 1'b1;
              // HALT has priority: a HALT that also fills memory is a clean end, not an overflow.
              overflow_q   <= !is_halt;
            end
          end

          // Shift bytes in MSB-first; the final byte completes the word and arms the write strobe.
          if (accept) begin
            if (byte_cnt_q == LAST_BYTE) begin
              data_q     <= {asm_q, i_rx_data};
              we_q       <= 1'b1;
              byte_cnt_q <= '0;
            end else begin
              asm_q      <= {asm_q[NB_ASM-NB_BYTE-1:0], i_rx_data};
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q      <= ST_IDLE;
          loading_q    <= 1'b0;
          done_q       <= 1'b0;
          pipe_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_we_IF            = we_q;
  assign o_instruction_data = data_q;
  assign o_pipe_rst_n       = pipe_rst_n_q;
  assign o_loading          = loading_q;
  assign o_done             = done_q;
  assign o_overflow         = overflow_q;
  assign o_word_count       = word_cnt_q;

endmodule

// File: doc/instr_loader.md
# instr_loader

Front end of the MIPS pipeline's instruction-memory write port. Receives a byte stream from the UART receiver, assembles MSB-first 32-bit instruction words and drives the pipeline's `i_we_IF`/`i_instruction_data` load interface with one-cycle write pulses. Holds the pipeline in reset while loading. Releases the pipeline when a HALT word arrives or instruction memory is full.

## Interface

Parameters:
- `NB_DATA`, default 32: instruction width in bits.
- `NB_BYTE`, default 8: UART byte width in bits.
- `NB_IADDR`, default 8: instruction-memory address bits; `MAX_WORDS = 2**NB_IADDR`.
- `HALT_WORD`, default 32'hFFFF_FFFF: end-of-program marker. It is written to memory like any other word.

Ports:
- `clk` input 1: single clock.
- `i_rst` input 1: reset, synchronous, active-high.
- `i_start` input 1: begin a load; sampled in IDLE and DONE only.
- `i_rx_data` input `NB_BYTE`: received byte.
- `i_rx_valid` input 1: one-cycle strobe, `i_rx_data` valid.
- `o_we_IF` output 1: instruction write strobe to the pipeline, one cycle per word.
- `o_instruction_data` output `NB_DATA`: assembled word; valid while `o_we_IF`=1.
- `o_pipe_rst_n` output 1: active-low pipeline reset; low except in DONE.
- `o_loading` output 1: high in LOAD.
- `o_done` output 1: high in DONE.
- `o_overflow` output 1: sticky; memory filled without a HALT word.
- `o_word_count` output `NB_IADDR+1`: number of words written in the current load.

## Operation

- States: IDLE, LOAD, DONE.
  - Reset enters IDLE.
  - IDLE -> LOAD on `i_start`.
  - LOAD -> DONE after writing HALT_WORD, or after writing the `MAX_WORDS`-th word.
  - DONE -> LOAD on `i_start`.
- Entering LOAD clears `o_word_count`, the byte counter and `o_overflow`.
- Byte assembly:
  - 2-bit byte counter; the first byte becomes bits [31:24], the fourth becomes bits [7:0].
  - Bytes are accepted only in LOAD. `i_rx_valid` in IDLE or DONE is ignored.
- On acceptance of the 4th byte:
  - The word is registered into `o_instruction_data`.
  - `o_we_IF`=1 on the next cycle for exactly one cycle.
  - The byte counter returns to 0.
  - `o_word_count` increments in the same cycle `o_we_IF` is high.
- Termination check uses the word being written:
  - If it equals HALT_WORD, go to DONE.
  - Else, if `o_word_count` reaches `MAX_WORDS` on that write, set `o_overflow` and go to DONE.
- A byte accepted in the `o_we_IF` cycle counts as byte 0 of the next word. Back-to-back bytes every cycle must be sustained with no loss, except when that write terminates the load: the byte is then dropped.
- `i_start` asserted while in LOAD is ignored.
- `o_instruction_data` holds its last value between writes.
- Reset mid-load: the partial word is discarded and no `o_we_IF` is issued. Then:
  - `o_pipe_rst_n` = 0.
  - All outputs go to their reset values.

## Timing

- Reset values:
  - IDLE state.
  - `o_we_IF`=0, `o_instruction_data`=0.
  - `o_pipe_rst_n`=0, `o_loading`=0, `o_done`=0, `o_overflow`=0, `o_word_count`=0.
- All outputs are registered.
- `i_start` sampled at edge E: `o_loading`=1 after E.
- 4th byte accepted at edge N:
  - `o_we_IF`=1 between N and N+1.
  - `o_word_count` updated after N+1.
- Termination on write cycle N+1: after edge N+1, `o_done`=1, `o_loading`=0 and `o_pipe_rst_n`=1. The pipeline therefore comes out of reset the cycle after the final write.
- DONE -> LOAD: `o_pipe_rst_n` falls after the edge that samples `i_start`.
- Minimum byte spacing: 1 cycle.

## Test plan

- **Reset values:** assert `i_rst` 2 cycles -> all outputs at reset values; `i_rx_valid` pulses in IDLE produce no `o_we_IF`.
- **Program load:** `i_start`, then bytes 20 00 00 14 / 20 02 00 1E / 00 22 18 21 / FF FF FF FF with gaps of 3 cycles ->
  - four `o_we_IF` pulses carrying 32'h20000014, 32'h2002001E, 32'h00221821, 32'hFFFFFFFF;
  - `o_word_count`=4, `o_done`=1;
  - `o_pipe_rst_n` rises the cycle after the 4th pulse.
- **Back-to-back bytes:** 12 bytes on consecutive cycles (words 32'h11223344, 32'h55667788, then HALT) -> 3 pulses with correct data and no dropped bytes.
- **Overflow:** `NB_IADDR`=2, send 4 non-HALT words -> 4 pulses, then `o_overflow`=1, `o_done`=1, `o_word_count`=4; further bytes ignored.
- **Reset mid-load:** `i_start`, 2 bytes, then `i_rst` -> no `o_we_IF`, state IDLE. A new load of 32'hFFFFFFFF then writes exactly one word.
- **Reload:** `i_start` in DONE -> `o_pipe_rst_n`=0, `o_word_count`=0, `o_overflow` cleared; the new word is written correctly.
